// File: rtl/ahb_bram_bridge.sv
// ahb_bram_bridge: zero-wait-state AHB-Lite slave onto a dual-port block RAM with write-to-read forwarding
module ahb_bram_bridge #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic [ADDR_WIDTH-1:0] bram_addra,
  output logic [31:0]           bram_dina,
  output logic [3:0]            bram_wea,
  output logic [ADDR_WIDTH-1:0] bram_addrb,
  input  logic [31:0]           bram_doutb
);
  typedef enum logic [1:0] {IDLE, WR_DATA, RD_DATA} state_t;
  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [3:0]              be_q, be_d, fwd_be_q, fwd_be_d;
  logic                    fwd_hit_q, fwd_hit_d;
  logic [31:0]             fwd_data_q, fwd_data_d;
  logic                    accept;
  logic [ADDR_WIDTH-1:0]   haddr_w;
  logic [3:0]              be;
  logic                    unused;
  assign accept    = HSEL & HTRANS[1] & HREADY;
  assign haddr_w   = HADDR[ADDR_WIDTH+1:2];
  assign unused    = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  // Byte lane strobes from transfer size and low address bits
  always_comb be = (HSIZE == 3'd0) ? 4'b0001 << HADDR[1:0] : (HSIZE == 3'd1) ? (HADDR[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  // Next state, address-phase capture, forwarding capture and RAM/bus outputs
  always_comb begin
    state_d    = accept ? (HWRITE ? WR_DATA : RD_DATA) : IDLE;
    wr_addr_d  = accept ? haddr_w : wr_addr_q;
    be_d       = accept ? be : be_q;
    fwd_hit_d  = (state_q == WR_DATA) & accept & ~HWRITE & (haddr_w == wr_addr_q);
    fwd_data_d = (state_q == WR_DATA) ? HWDATA : fwd_data_q;
    fwd_be_d   = (state_q == WR_DATA) ? be_q : fwd_be_q;
    bram_addra = wr_addr_q;
    bram_dina  = HWDATA;
    bram_wea   = (state_q == WR_DATA) ? be_q : 4'b0000;
    bram_addrb = haddr_w;
    HRDATA     = '0;
    for (int i = 0; i < 4; i++)
      HRDATA[8*i +: 8] = (state_q != RD_DATA) ? 8'h00 : (fwd_hit_q & fwd_be_q[i]) ? fwd_data_q[8*i +: 8] : bram_doutb[8*i +: 8];
  end
  // State and captured-phase registers
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q    <= IDLE;
      wr_addr_q  <= '0;
      be_q       <= '0;
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
      fwd_be_q   <= '0;
    end else begin
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      be_q       <= be_d;
      fwd_hit_q  <= fwd_hit_d;
      fwd_data_q <= fwd_data_d;
      fwd_be_q   <= fwd_be_d;
    end
  end
endmodule

// File: tb/tb_ahb_bram_bridge.sv
// tb_ahb_bram_bridge: directed self-checking bench with a behavioural dual-port RAM
module tb_ahb_bram_bridge;
  logic        HCLK = 1'b0, HRESET = 1'b1, HSEL = 1'b0, HWRITE = 1'b0, HREADY = 1'b1;
  logic [31:0] HADDR = '0, HWDATA = '0;
  logic [1:0]  HTRANS = 2'b00;
  logic [2:0]  HSIZE = 3'd0;
  logic        HREADYOUT, HRESP;
  logic [31:0] HRDATA, bram_dina, bram_doutb;
  logic [11:0] bram_addra, bram_addrb;
  logic [3:0]  bram_wea;
  logic        clr = 1'b1;
  logic [31:0] mem [0:4095];
  int          errors = 0, checks = 0;
  ahb_bram_bridge #(.ADDR_WIDTH(12)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .bram_addra(bram_addra), .bram_dina(bram_dina), .bram_wea(bram_wea),
    .bram_addrb(bram_addrb), .bram_doutb(bram_doutb)
  );
  always #5 HCLK = ~HCLK;
  // Read-before-write dual-port RAM, cleared while clr is high
  always @(posedge HCLK) begin
    if (clr) begin
      for (int i = 0; i < 4096; i++) mem[i] <= '0;
      bram_doutb <= '0;
    end else begin
      for (int i = 0; i < 4; i++) if (bram_wea[i]) mem[bram_addra][8*i +: 8] <= bram_dina[8*i +: 8];
      bram_doutb <= mem[bram_addrb];
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // One bus cycle: new address phase plus write data for the previous transfer; returns at the following negedge
  task automatic cyc(input logic sel, input logic act, input logic wr, input logic [2:0] sz,
                     input logic [31:0] addr, input logic [31:0] wdata);
    @(posedge HCLK);
    #1;
    HSEL = sel; HTRANS = act ? 2'b10 : 2'b00; HWRITE = wr; HSIZE = sz; HADDR = addr; HWDATA = wdata;
    @(negedge HCLK);
  endtask
  initial begin
    repeat (2) @(posedge HCLK);
    #1;
    chk("rst_wea", {28'd0, bram_wea}, 32'd0);
    chk("rst_hrdata", HRDATA, 32'd0);
    chk("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    chk("rst_hresp", {31'd0, HRESP}, 32'd0);
    @(negedge HCLK);
    HRESET = 1'b0; clr = 1'b0;
    // word write then read after an idle cycle
    cyc(1, 1, 1, 3'd2, 32'h10, 32'h0);
    cyc(1, 0, 0, 3'd2, 32'h0, 32'hDEADBEEF);
    chk("t1_wea", {28'd0, bram_wea}, 32'hF);
    chk("t1_addra", {20'd0, bram_addra}, 32'd4);
    chk("t1_dina", bram_dina, 32'hDEADBEEF);
    cyc(1, 1, 0, 3'd2, 32'h10, 32'h0);
    cyc(1, 0, 0, 3'd2, 32'h0, 32'h0);
    chk("t1_hrdata", HRDATA, 32'hDEADBEEF);
    // byte then halfword write, read back merged word
    cyc(1, 1, 1, 3'd0, 32'h21, 32'h0);
    cyc(1, 1, 1, 3'd1, 32'h22, 32'h00001100);
    chk("t2_wea_byte", {28'd0, bram_wea}, 32'h2);
    chk("t2_addra", {20'd0, bram_addra}, 32'd8);
    cyc(1, 0, 0, 3'd2, 32'h0, 32'hAABB0000);
    chk("t2_wea_half", {28'd0, bram_wea}, 32'hC);
    cyc(1, 1, 0, 3'd2, 32'h20, 32'h0);
    chk("t2_idle_hrdata", HRDATA, 32'd0);
    cyc(1, 0, 0, 3'd2, 32'h0, 32'h0);
    chk("t2_hrdata", HRDATA, 32'hAABB1100);
    // write immediately followed by read of the same word
    cyc(1, 1, 1, 3'd2, 32'h40, 32'h0);
    cyc(1, 1, 0, 3'd2, 32'h40, 32'h12345678);
    chk("t3_wea", {28'd0, bram_wea}, 32'hF);
    chk("t3_wr_hrdata", HRDATA, 32'd0);
    cyc(1, 0, 0, 3'd2, 32'h0, 32'h0);
    chk("t3_ram_old", bram_doutb, 32'd0);
    chk("t3_hrdata_fwd", HRDATA, 32'h12345678);
    // byte write forwarded into lane 3 only
    cyc(1, 1, 1, 3'd0, 32'h43, 32'h0);
    cyc(1, 1, 0, 3'd2, 32'h40, 32'hFF000000);
    chk("t4_wea", {28'd0, bram_wea}, 32'h8);
    cyc(1, 0, 0, 3'd2, 32'h0, 32'h0);
    chk("t4_ram_old", bram_doutb, 32'h12345678);
    chk("t4_hrdata_merge", HRDATA, 32'hFF345678);
    // write to one word, read of the neighbour must not forward
    cyc(1, 1, 1, 3'd2, 32'h44, 32'h0);
    cyc(1, 1, 1, 3'd2, 32'h40, 32'h55667788);
    cyc(1, 1, 0, 3'd2, 32'h44, 32'hA5A5A5A5);
    cyc(1, 0, 0, 3'd2, 32'h0, 32'h0);
    chk("t5_no_fwd", HRDATA, 32'h55667788);
    // aliased address reads word 0x10
    cyc(1, 1, 0, 3'd2, 32'h4040, 32'h0);
    cyc(1, 0, 0, 3'd2, 32'h0, 32'h0);
    chk("t5_alias", HRDATA, 32'hA5A5A5A5);
    // unselected write must not touch the RAM
    cyc(0, 1, 1, 3'd2, 32'h40, 32'h0);
    cyc(1, 0, 0, 3'd2, 32'h0, 32'h01020304);
    chk("t5_hsel0_wea", {28'd0, bram_wea}, 32'd0);
    // reset during a write data phase
    cyc(1, 1, 1, 3'd2, 32'h8, 32'h0);
    cyc(1, 0, 0, 3'd2, 32'h0, 32'hCAFEF00D);
    chk("t6_wea_before", {28'd0, bram_wea}, 32'hF);
    HRESET = 1'b1;
    #1;
    chk("t6_wea_rst", {28'd0, bram_wea}, 32'd0);
    chk("t6_hrdata_rst", HRDATA, 32'd0);
    @(posedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
    chk("t6_ram_word2", mem[2], 32'd0);
    chk("t6_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    cyc(1, 1, 0, 3'd2, 32'h8, 32'h0);
    cyc(1, 0, 0, 3'd2, 32'h0, 32'h0);
    chk("t6_read_word2", HRDATA, 32'd0);
    chk("t6_ram_word10", mem[16], 32'hA5A5A5A5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
